fft16_input_buffer: RTL and testbench
=====================================

# fft16_input_buffer

Ping-pong frame buffer feeding the first radix-4 butterfly stage of the 16-point FFT. Accepts complex samples serially in natural order (x[0]..x[15]) and, once a frame is complete, issues four groups {x[g], x[g+4], x[g+8], x[g+12]}, g = 0..3, on the butterfly's A/B/C/D inputs. Two 16-entry banks allow the next frame to be written while the current one drains.

## Interface

Parameters:
- WIDTH, 16, bit width of each real/imag component (two's complement).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present on in_re/in_im.
- in_ready  out  1  buffer can accept a sample this cycle.
- in_first  in  1  qualifies a sample as x[0] of a new frame.
- in_re, in_im  in  WIDTH  sample real/imag, signed.
- grp_valid  out  1  group outputs valid.
- grp_ready  in  1  downstream accepts the group.
- grp_idx  out  2  group index g (0..3).
- grp_last  out  1  high when g == 3.
- a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im  out  WIDTH each  x[g], x[g+4], x[g+8], x[g+12].
- sync_err  out  1  one-cycle pulse: in_first accepted with write index != 0.

## Operation

- State: bank storage mem[2][16] (re, im), full[1:0], wr_bank, wr_idx[3:0], rd_bank, rd_g[1:0].
- in_ready = !full[wr_bank]. Sample accepted on in_valid && in_ready.
- Accept: if in_first, sample is written to index 0 and wr_idx <= 1 (partial frame discarded; sync_err pulses next cycle if wr_idx != 0). Else written at wr_idx, wr_idx increments.
- Write at index 15: full[wr_bank] <= 1, wr_bank toggles, wr_idx <= 0.
- grp_valid = full[rd_bank]. Data outputs are muxed from mem[rd_bank] by rd_g only; no combinational path from in_* to grp_* or a..d.
- grp_idx = rd_g; grp_last = (rd_g == 3).
- Transfer on grp_valid && grp_ready: rd_g increments; on g == 3, full[rd_bank] <= 0, rd_bank toggles, rd_g <= 0.
- Output data held stable while grp_valid && !grp_ready.
- Simultaneous set/clear: a bank being freed by the read side and a different bank being filled in the same cycle both take effect. Read side never frees the bank being written (it is not full).
- Both banks full: in_ready = 0 until the read side frees one; no sample loss, no overwrite.
- Values are stored and forwarded unchanged (no scaling, no sign handling beyond bit copy).

## Timing

- Reset (rst high at edge): full = 0, wr_bank = rd_bank = 0, wr_idx = 0, rd_g = 0, sync_err = 0, mem cleared to 0. Resulting outputs: grp_valid = 0, grp_idx = 0, grp_last = 0, a..d = 0, in_ready = 1. Samples presented during a reset cycle are discarded.
- Reset mid-frame or mid-drain: all partial and buffered frames are dropped; no group issued afterwards until 16 new samples are written.
- Latency: 16th sample accepted at edge t -> grp_valid = 1 with grp_idx = 0 in the cycle after t.
- Throughput: with grp_ready held high, a frame drains in 4 cycles; sustained input at 1 sample/cycle never deasserts in_ready.
- sync_err registered, high exactly one cycle after the offending accept.

## Test plan

- Reset then 16 samples re = n, im = -n (n = 0..15), grp_ready = 1 -> 4 consecutive groups; g=1 gives A=(1,-1), B=(5,-5), C=(9,-9), D=(13,-13); grp_last only on g=3.
- Backpressure: full frame, grp_ready = 0 for 10 cycles -> grp_valid held, g=0 data stable; release -> groups 0..3 in order, none skipped or repeated.
- Overflow stall: grp_ready = 0, stream 40 samples -> in_ready drops after sample 32; release -> frames 1 and 2 emitted intact, remaining 8 samples then accepted.
- Resync: 7 samples, then in_first with value 100 plus 15 more -> sync_err pulses once; first group A.re = 100; the 7 stale samples never appear.
- Continuous 1 sample/cycle for 5 frames with grp_ready = 1 -> in_ready never low, 20 groups, values match frame order; sign extremes (-32768, 32767) pass unchanged.
- Reset asserted at sample 10 and again during group 2 of a full frame -> grp_valid 0 next cycle, outputs 0, next full frame emitted normally.

Source files
------------

// File: rtl/fft16_input_buffer.sv
// Two-bank ping-pong frame buffer: 16 samples in natural order, drained as four
// radix-4 groups {x[g], x[g+4], x[g+8], x[g+12]} for the first butterfly stage.
module fft16_input_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             grp_valid,
    input  logic             grp_ready,
    output logic [1:0]       grp_idx,
    output logic             grp_last,
    output logic [WIDTH-1:0] a_re,
    output logic [WIDTH-1:0] a_im,
    output logic [WIDTH-1:0] b_re,
    output logic [WIDTH-1:0] b_im,
    output logic [WIDTH-1:0] c_re,
    output logic [WIDTH-1:0] c_im,
    output logic [WIDTH-1:0] d_re,
    output logic [WIDTH-1:0] d_im,
    output logic             sync_err
);

    logic [WIDTH-1:0] r_mem_re [2][16];
    logic [WIDTH-1:0] r_mem_im [2][16];
    logic [1:0]       r_full;
    logic             r_wr_bank;
    logic [3:0]       r_wr_idx;
    logic             r_rd_bank;
    logic [1:0]       r_rd_g;
    logic             r_sync_err;

    logic             w_accept;
    logic [3:0]       w_wr_addr;
    logic             w_wr_end;
    logic             w_xfer;
    logic             w_rd_end;
    logic [1:0]       w_full_nxt;

    assign in_ready  = !r_full[r_wr_bank];
    assign w_accept  = in_valid && in_ready;
    assign w_wr_addr = in_first ? 4'd0 : r_wr_idx;
    assign w_wr_end  = w_accept && (w_wr_addr == 4'd15);

    assign grp_valid = r_full[r_rd_bank];
    assign w_xfer    = grp_valid && grp_ready;
    assign w_rd_end  = w_xfer && (r_rd_g == 2'd3);

    // The read side only ever frees a full bank and the write side only fills
    // a non-full one, so both updates can land in the same cycle.
    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_end) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_wr_end) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 16; i++) begin
                    r_mem_re[b][i] <= '0;
                    r_mem_im[b][i] <= '0;
                end
            end
        end else if (w_accept) begin
            r_mem_re[r_wr_bank][w_wr_addr] <= in_re;
            r_mem_im[r_wr_bank][w_wr_addr] <= in_im;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_wr_idx   <= 4'd0;
            r_rd_bank  <= 1'b0;
            r_rd_g     <= 2'd0;
            r_sync_err <= 1'b0;
        end else begin
            r_full     <= w_full_nxt;
            r_sync_err <= w_accept && in_first && (r_wr_idx != 4'd0);
            if (w_accept) begin
                if (w_wr_end) begin
                    r_wr_bank <= !r_wr_bank;
                    r_wr_idx  <= 4'd0;
                end else begin
                    r_wr_idx  <= w_wr_addr + 4'd1;
                end
            end
            if (w_xfer) begin
                r_rd_g <= r_rd_g + 2'd1;
                if (w_rd_end) begin
                    r_rd_bank <= !r_rd_bank;
                end
            end
        end
    end

    // Output mux depends only on registered read pointers.
    assign grp_idx  = r_rd_g;
    assign grp_last = (r_rd_g == 2'd3);
    assign sync_err = r_sync_err;

    assign a_re = r_mem_re[r_rd_bank][{2'b00, r_rd_g}];
    assign a_im = r_mem_im[r_rd_bank][{2'b00, r_rd_g}];
    assign b_re = r_mem_re[r_rd_bank][{2'b01, r_rd_g}];
    assign b_im = r_mem_im[r_rd_bank][{2'b01, r_rd_g}];
    assign c_re = r_mem_re[r_rd_bank][{2'b10, r_rd_g}];
    assign c_im = r_mem_im[r_rd_bank][{2'b10, r_rd_g}];
    assign d_re = r_mem_re[r_rd_bank][{2'b11, r_rd_g}];
    assign d_im = r_mem_im[r_rd_bank][{2'b11, r_rd_g}];

endmodule

// File: tb/tb_fft16_input_buffer.sv
// Directed bench for fft16_input_buffer: framing, grouping, backpressure,
// overflow stall, resync and mid-operation reset.
module tb_fft16_input_buffer;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic [WIDTH-1:0] in_re;
    logic [WIDTH-1:0] in_im;
    logic             grp_valid;
    logic             grp_ready;
    logic [1:0]       grp_idx;
    logic             grp_last;
    logic [WIDTH-1:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;
    logic             sync_err;
    logic [127:0]     w_grp;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign w_grp = {a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im};

    fft16_input_buffer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
        .in_re(in_re), .in_im(in_im),
        .grp_valid(grp_valid), .grp_ready(grp_ready),
        .grp_idx(grp_idx), .grp_last(grp_last),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .c_re(c_re), .c_im(c_im), .d_re(d_re), .d_im(d_im),
        .sync_err(sync_err)
    );

    function automatic logic [127:0] mk(input int ar, input int ai, input int br, input int bi,
                                        input int cr, input int ci, input int dr, input int di);
        return {16'(ar), 16'(ai), 16'(br), 16'(bi), 16'(cr), 16'(ci), 16'(dr), 16'(di)};
    endfunction

    // Sample values for the continuous test; frame 4 carries the sign extremes.
    function automatic int vre(input int f, input int n);
        if (f == 4 && n == 0)  return -32768;
        if (f == 4 && n == 12) return 32767;
        return f * 37 + n * 3 - 20;
    endfunction

    function automatic int vim(input int f, input int n);
        if (f == 4 && n == 0)  return 32767;
        if (f == 4 && n == 12) return -32768;
        return -(f * 11 + n * 5);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; grp_ready = 1'b0;
        in_re = '0; in_im = '0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic send(input int re, input int im, input bit first);
        in_valid = 1'b1; in_first = first;
        in_re = 16'(re); in_im = 16'(im);
        tick;
        in_valid = 1'b0; in_first = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; grp_ready = 1'b0;
        in_valid = 1'b1; in_first = 1'b1; in_re = 16'h1234; in_im = 16'h4321;
        tick; tick;
        rst = 1'b0; in_valid = 1'b0; in_first = 1'b0;
        n_checks++;
        if ({grp_valid, grp_idx, grp_last, sync_err} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {grp_valid, grp_idx, grp_last, sync_err});
        else n_pass++;
        n_checks++;
        if (w_grp !== 128'd0) $display("FAIL reset_data: got %h want 0", w_grp);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        // A sample offered during reset must not count toward a frame.
        for (int n = 0; n < 15; n++) send(n, n, 1'b0);
        n_checks++;
        if (grp_valid !== 1'b0) $display("FAIL reset_discard: grp_valid got %b want 0", grp_valid);
        else n_pass++;
    endtask

    task automatic test_basic;
        do_reset;
        grp_ready = 1'b1;
        for (int n = 0; n < 16; n++) send(n, -n, n == 0);
        for (int g = 0; g < 4; g++) begin
            n_checks++;
            if ({grp_valid, grp_idx, grp_last} !== {1'b1, 2'(g), g == 3})
                $display("FAIL basic_ctrl g=%0d: got %b want %b", g, {grp_valid, grp_idx, grp_last}, {1'b1, 2'(g), g == 3});
            else n_pass++;
            n_checks++;
            if (w_grp !== mk(g, -g, g + 4, -(g + 4), g + 8, -(g + 8), g + 12, -(g + 12)))
                $display("FAIL basic_data g=%0d: got %h want %h", g, w_grp, mk(g, -g, g + 4, -(g + 4), g + 8, -(g + 8), g + 12, -(g + 12)));
            else n_pass++;
            tick;
        end
        n_checks++;
        if (grp_valid !== 1'b0) $display("FAIL basic_drained: grp_valid got %b want 0", grp_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        int bad;
        do_reset;
        for (int n = 0; n < 16; n++) send(20 + n, 40 + n, n == 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({grp_valid, grp_idx, w_grp} !== {1'b1, 2'd0, mk(20, 40, 24, 44, 28, 48, 32, 52)}) bad++;
            tick;
        end
        n_checks++;
        if (bad != 0) $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
        else n_pass++;
        grp_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            n_checks++;
            if ({grp_valid, grp_idx, w_grp} !== {1'b1, 2'(g), mk(20 + g, 40 + g, 24 + g, 44 + g, 28 + g, 48 + g, 32 + g, 52 + g)})
                $display("FAIL bp_release g=%0d: got %b/%0d/%h", g, grp_valid, grp_idx, w_grp);
            else n_pass++;
            tick;
        end
        n_checks++;
        if (grp_valid !== 1'b0) $display("FAIL bp_no_repeat: grp_valid got %b want 0", grp_valid);
        else n_pass++;
    endtask

    task automatic test_overflow;
        int bad;
        int f;
        int g;
        int base;
        do_reset;
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (in_ready !== 1'b1) bad++;
            send(k, 1000 + k, 1'b0);
        end
        n_checks++;
        if (bad != 0) $display("FAIL ovf_accept32: in_ready low %0d times, want 0", bad);
        else n_pass++;
        in_valid = 1'b1; in_re = 16'd32; in_im = 16'd1032;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (in_ready !== 1'b0) bad++;
            tick;
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad != 0) $display("FAIL ovf_stall: in_ready high %0d times, want 0", bad);
        else n_pass++;
        grp_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            f = j / 4; g = j % 4; base = 16 * f + g;
            n_checks++;
            if ({grp_valid, grp_idx, w_grp} !== {1'b1, 2'(g), mk(base, 1000 + base, base + 4, 1004 + base,
                                                              base + 8, 1008 + base, base + 12, 1012 + base)})
                $display("FAIL ovf_drain f=%0d g=%0d: got %b/%0d/%h", f, g, grp_valid, grp_idx, w_grp);
            else n_pass++;
            tick;
        end
        n_checks++;
        if ({grp_valid, in_ready} !== 2'b01) $display("FAIL ovf_after_drain: valid/ready got %b want 01", {grp_valid, in_ready});
        else n_pass++;
        bad = 0;
        for (int k = 32; k < 40; k++) begin
            if (in_ready !== 1'b1) bad++;
            send(k, 1000 + k, 1'b0);
        end
        n_checks++;
        if (bad != 0 || grp_valid !== 1'b0) $display("FAIL ovf_remaining: ready-low %0d grp_valid %b, want 0 and 0", bad, grp_valid);
        else n_pass++;
    endtask

    task automatic test_resync;
        int pulses;
        do_reset;
        grp_ready = 1'b1;
        pulses = 0;
        for (int n = 0; n < 7; n++) begin
            send(500 + n, -500 - n, n == 0);
            if (sync_err) pulses++;
        end
        n_checks++;
        if (pulses != 0) $display("FAIL resync_quiet: sync_err pulses %0d want 0", pulses);
        else n_pass++;
        send(100, -100, 1'b1);
        n_checks++;
        if (sync_err !== 1'b1) $display("FAIL resync_pulse: sync_err got %b want 1", sync_err);
        else n_pass++;
        pulses = 0;
        for (int n = 1; n < 16; n++) begin
            send(100 + n, -100 - n, 1'b0);
            if (sync_err) pulses++;
        end
        n_checks++;
        if (pulses != 0) $display("FAIL resync_one_pulse: extra pulses %0d want 0", pulses);
        else n_pass++;
        for (int g = 0; g < 4; g++) begin
            n_checks++;
            if ({grp_valid, grp_idx, w_grp} !== {1'b1, 2'(g), mk(100 + g, -100 - g, 104 + g, -104 - g,
                                                              108 + g, -108 - g, 112 + g, -112 - g)})
                $display("FAIL resync_data g=%0d: got %b/%0d/%h", g, grp_valid, grp_idx, w_grp);
            else n_pass++;
            tick;
        end
        n_checks++;
        if (grp_valid !== 1'b0) $display("FAIL resync_no_stale: grp_valid got %b want 0", grp_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int gc;
        int low;
        int bad;
        int errs;
        int f;
        int g;
        do_reset;
        grp_ready = 1'b1;
        gc = 0; low = 0; bad = 0; errs = 0;
        for (int s = 0; s < 88; s++) begin
            if (s < 80) begin
                in_valid = 1'b1; in_first = (s % 16 == 0);
                in_re = 16'(vre(s / 16, s % 16)); in_im = 16'(vim(s / 16, s % 16));
                if (in_ready !== 1'b1) low++;
            end else begin
                in_valid = 1'b0; in_first = 1'b0;
            end
            if (sync_err) errs++;
            if (grp_valid === 1'b1) begin
                f = gc / 4; g = gc % 4;
                if (gc >= 20 || {grp_idx, grp_last} !== {2'(g), g == 3} ||
                    w_grp !== mk(vre(f, g), vim(f, g), vre(f, g + 4), vim(f, g + 4),
                                 vre(f, g + 8), vim(f, g + 8), vre(f, g + 12), vim(f, g + 12))) begin
                    bad++;
                    $display("FAIL b2b_group %0d: got idx %0d data %h", gc, grp_idx, w_grp);
                end
                gc++;
            end
            tick;
        end
        n_checks++;
        if (low != 0) $display("FAIL b2b_in_ready: low %0d cycles want 0", low);
        else n_pass++;
        n_checks++;
        if (gc != 20) $display("FAIL b2b_count: groups %0d want 20", gc);
        else n_pass++;
        n_checks++;
        if (bad != 0 || errs != 0) $display("FAIL b2b_data: bad groups %0d sync_err %0d want 0 and 0", bad, errs);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset;
        grp_ready = 1'b1;
        for (int n = 0; n < 10; n++) send(700 + n, 700 + n, n == 0);
        rst = 1'b1; in_valid = 1'b1; in_re = 16'h5555; in_im = 16'h5555;
        tick;
        rst = 1'b0; in_valid = 1'b0;
        n_checks++;
        if ({grp_valid, grp_idx, in_ready, w_grp} !== {1'b0, 2'd0, 1'b1, 128'd0})
            $display("FAIL rstmid_frame: got %b/%0d/%b/%h", grp_valid, grp_idx, in_ready, w_grp);
        else n_pass++;
        for (int n = 0; n < 6; n++) send(200 + n, -200 - n, n == 0);
        n_checks++;
        if (grp_valid !== 1'b0) $display("FAIL rstmid_partial: grp_valid got %b want 0", grp_valid);
        else n_pass++;
        for (int n = 6; n < 16; n++) send(200 + n, -200 - n, 1'b0);
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if ({grp_valid, grp_idx, w_grp} !== {1'b1, 2'(g), mk(200 + g, -200 - g, 204 + g, -204 - g,
                                                              208 + g, -208 - g, 212 + g, -212 - g)})
                $display("FAIL rstmid_pre g=%0d: got %b/%0d/%h", g, grp_valid, grp_idx, w_grp);
            else n_pass++;
            if (g < 2) tick;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++;
        if ({grp_valid, grp_idx, grp_last, w_grp} !== 131'd0)
            $display("FAIL rstmid_drain: got %b/%0d/%b/%h", grp_valid, grp_idx, grp_last, w_grp);
        else n_pass++;
        tick; tick; tick;
        n_checks++;
        if (grp_valid !== 1'b0) $display("FAIL rstmid_quiet: grp_valid got %b want 0", grp_valid);
        else n_pass++;
        for (int n = 0; n < 16; n++) send(300 + n, -300 - n, n == 0);
        for (int g = 0; g < 4; g++) begin
            n_checks++;
            if ({grp_valid, grp_idx, w_grp} !== {1'b1, 2'(g), mk(300 + g, -300 - g, 304 + g, -304 - g,
                                                              308 + g, -308 - g, 312 + g, -312 - g)})
                $display("FAIL rstmid_next g=%0d: got %b/%0d/%h", g, grp_valid, grp_idx, w_grp);
            else n_pass++;
            tick;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; grp_ready = 1'b0;
        in_re = '0; in_im = '0;
        #2;
        test_reset;
        test_basic;
        test_backpressure;
        test_overflow;
        test_resync;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
